// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input,
// counted in timebase ticks. The input is synchronized, optionally inverted
// and optionally glitch-filtered before edge detection.
//
// Build option: define PWM_CAPTURE_GLITCH_FILTER_EN to compile in the glitch
// filter. The input must then hold a new level for FILT_LEN consecutive clocks
// before it is accepted. Without the macro there is no filter logic and
// FILT_LEN is ignored.
//
// state        | meaning
// -------------|-------------------------------------------------------------
// ST_IDLE      | capture disabled; cnt cleared, results and flags held
// ST_WAIT_RISE | armed; waiting for the first rising edge to start a period
// ST_MEAS_HIGH | counting the high phase since the last rising edge
// ST_MEAS_LOW  | falling edge seen; counting until the next rising edge
module pwm_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       tick,
  input  logic       cap_in,
  input  logic       inv,
  input  logic [1:0] intr_en,
  input  logic [1:0] flag_clr,
  output logic [7:0] high_time,
  output logic [7:0] period,
  output logic       done,
  output logic [1:0] flag,
  output logic [1:0] intr
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_MEAS_HIGH = 2'd2,
    ST_MEAS_LOW  = 2'd3
  } state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   x_in;
  logic                   s_pre;
  logic                   s_in;
  logic                   s_d;
  logic                   rise;
  logic                   fall;
  logic [7:0]             cnt, cnt_nxt, cnt_inc;
  logic [7:0]             high_nxt, period_nxt;
  logic                   cnt_full;
  logic                   upd;
  logic                   ovf;
  logic                   done_pend;
  logic [1:0]             flag_nxt;

  // Reject parameter values the datapath cannot support.
  generate
    if (SYNC_STAGES < 2) begin : g_sync_chk
      $error("pwm_capture: SYNC_STAGES must be at least 2");
    end
    if (FILT_LEN < 1) begin : g_filt_chk
      $error("pwm_capture: FILT_LEN must be at least 1");
    end
  endgenerate

  // Metastability synchronizer for the asynchronous PWM input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], cap_in};
  end

  assign x_in = sync_q[SYNC_STAGES-1] ^ inv;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int FW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN + 1);

  logic [FW-1:0] filt_cnt;
  logic          filt_q;

  // Accept a new level only after FILT_LEN consecutive samples disagree with the current one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_cnt <= '0;
      filt_q   <= 1'b0;
    end else if (x_in == filt_q) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
      filt_cnt <= '0;
      filt_q   <= x_in;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign s_pre = filt_q;
`else
  assign s_pre = x_in;
`endif

  // Conditioned input and its one-cycle delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_in <= 1'b0;
      s_d  <= 1'b0;
    end else begin
      s_in <= s_pre;
      s_d  <= s_in;
    end
  end

  assign rise     = s_in & ~s_d;
  assign fall     = ~s_in & s_d;
  assign cnt_inc  = cnt + {7'd0, tick};
  assign cnt_full = (cnt == 8'hFF) & tick & ~rise & ~fall;

  // Next-state, elapsed counter and result update decisions.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    high_nxt   = high_time;
    period_nxt = period;
    upd        = 1'b0;
    ovf        = 1'b0;
    if (!en) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_WAIT_RISE;
        end
        ST_WAIT_RISE: begin
          if (rise) begin
            state_nxt = ST_MEAS_HIGH;
            cnt_nxt   = {7'd0, tick};
          end
        end
        ST_MEAS_HIGH: begin
          if (rise) begin
            // Missed falling edge: the whole period counts as high time.
            high_nxt   = cnt;
            period_nxt = cnt;
            upd        = 1'b1;
            cnt_nxt    = {7'd0, tick};
          end else if (fall) begin
            high_nxt  = cnt;
            cnt_nxt   = cnt_inc;
            state_nxt = ST_MEAS_LOW;
          end else if (cnt_full) begin
            ovf       = 1'b1;
            cnt_nxt   = 8'd0;
            state_nxt = ST_WAIT_RISE;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        ST_MEAS_LOW: begin
          if (rise) begin
            period_nxt = cnt;
            upd        = 1'b1;
            cnt_nxt    = {7'd0, tick};
            state_nxt  = ST_MEAS_HIGH;
          end else if (cnt_full) begin
            ovf       = 1'b1;
            cnt_nxt   = 8'd0;
            state_nxt = ST_WAIT_RISE;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 8'd0;
        end
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a clear takes priority.
  always_comb begin
    flag_nxt    = flag;
    flag_nxt[0] = upd | (flag[0] & ~flag_clr[0]);
    flag_nxt[1] = ovf | (flag[1] & ~flag_clr[1]);
  end

  // State, counter and measurement result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= 8'd0;
      high_time <= 8'd0;
      period    <= 8'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      high_time <= high_nxt;
      period    <= period_nxt;
    end
  end

  // done trails the result update by one cycle; flags update with the results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_pend <= 1'b0;
      done      <= 1'b0;
      flag      <= 2'b00;
    end else begin
      done_pend <= upd;
      done      <= done_pend;
      flag      <= flag_nxt;
    end
  end

  assign intr = flag & intr_en;

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized self-checking bench for pwm_capture. A reference model computes
// expected results from per-cycle input history: the conditioned input is the
// recorded input delayed by the synchronizer depth, and measurements are tick
// sums over windows between edges (prefix sums).
module tb_pwm_capture;
  localparam int SYNC = 2;
  localparam int FILT = 3;
  localparam int N    = 16384;

  logic       clk;
  logic       rst;
  logic       en;
  logic       tick;
  logic       cap_in;
  logic       inv;
  logic [1:0] intr_en;
  logic [1:0] flag_clr;
  logic [7:0] high_time;
  logic [7:0] period;
  logic       done;
  logic [1:0] flag;
  logic [1:0] intr;

  pwm_capture #(.SYNC_STAGES(SYNC), .FILT_LEN(FILT)) dut (
    .clk(clk), .rst(rst), .en(en), .tick(tick), .cap_in(cap_in), .inv(inv),
    .intr_en(intr_en), .flag_clr(flag_clr), .high_time(high_time),
    .period(period), .done(done), .flag(flag), .intr(intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // input history, indexed by the clock edge that samples it
  bit       xh[N];
  bit       fh[N];
  bit       th[N];
  bit       eh[N];
  bit [1:0] ch[N];
  int       pre[N];
  int       k;

  // reference model state
  bit         armed;
  bit         fall_seen;
  bit         pend;
  bit         exp_done;
  bit         clr_on_upd;
  bit         en_lvl;
  int         rk;
  logic [7:0] m_high;
  logic [7:0] m_period;
  logic [1:0] m_flag;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // conditioned input level as seen by the measurement logic at edge j
  function automatic bit sv(input int j);
    int i;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    i = j - SYNC - 2;
    return (i < 1) ? 1'b0 : fh[i];
`else
    i = j - SYNC - 1;
    return (i < 1) ? 1'b0 : xh[i];
`endif
  endfunction

  task automatic model_reset();
    k = 0; xh[0] = 0; fh[0] = 0; th[0] = 0; eh[0] = 0; ch[0] = 0; pre[0] = 0;
    armed = 0; fall_seen = 0; pend = 0; exp_done = 0; rk = -1;
    m_high = 0; m_period = 0; m_flag = 0;
  endtask

  task automatic model_edge();
    bit r, f, setd, seto;
    int w;
    r = sv(k) && !sv(k-1);
    f = !sv(k) && sv(k-1);
    exp_done = pend;
    pend = 0; setd = 0; seto = 0;
    if (!eh[k]) begin
      armed = 0; rk = -1;
    end else if (!armed) begin
      armed = 1;
    end else if (r) begin
      if (rk >= 0) begin
        w = (pre[k-1] - pre[rk-1]) % 256;
        if (!fall_seen) m_high = 8'(w);
        m_period = 8'(w);
        pend = 1; setd = 1;
      end
      rk = k; fall_seen = 0;
    end else if (rk >= 0) begin
      if (f && !fall_seen) begin
        m_high = 8'((pre[k-1] - pre[rk-1]) % 256);
        fall_seen = 1;
      end else if (!f && th[k] && ((pre[k] - pre[rk-1]) % 256 == 0)) begin
        seto = 1; rk = -1;
      end
    end
    m_flag[0] = setd | (m_flag[0] & ~ch[k][0]);
    m_flag[1] = seto | (m_flag[1] & ~ch[k][1]);
  endtask

  // one clock: drive at negedge, let the edge happen, compare at next negedge
  task automatic cyc(input bit c, input bit t, input bit e, input bit [1:0] clr);
    bit [1:0] cl;
    bit same;
    if (k >= N - 2) begin
      $display("FAIL model_capacity: index %0d required below %0d", k, N - 2);
      $fatal(1);
    end
    cl = clr;
    k++;
    xh[k] = c ^ inv; th[k] = t; eh[k] = e; pre[k] = pre[k-1] + int'(t);
    same = 1;
    for (int i = 0; i < FILT; i++)
      if (k - i < 1 || xh[k-i] != xh[k]) same = 0;
    fh[k] = same ? xh[k] : fh[k-1];
    if (clr_on_upd && e && armed && rk >= 0 && sv(k) && !sv(k-1)) cl[0] = 1'b1;
    ch[k] = cl;
    cap_in = c; tick = t; en = e; flag_clr = cl;
    @(posedge clk);
    @(negedge clk);
    model_edge();
    chk("done", done, exp_done);
    chk("high_time", high_time, m_high);
    chk("period", period, m_period);
    chk("flag", flag, m_flag);
    chk("intr", intr, m_flag & intr_en);
  endtask

  // tp > 0: tick every tp-th cycle; tp == 0: no ticks; tp < 0: random density -tp/4
  task automatic seg(input bit lvl, input int len, input int tp, input bit rclr);
    bit t;
    bit [1:0] cl;
    for (int i = 0; i < len; i++) begin
      if (tp > 0)       t = ((k + 1) % tp) == 0;
      else if (tp == 0) t = 1'b0;
      else              t = int'($urandom_range(1, 4)) <= -tp;
      cl = 2'b00;
      if (rclr) cl = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      cyc(lvl, t, en_lvl, cl);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; tick = 1'b0; cap_in = 1'b0; flag_clr = 2'b00; en_lvl = 1'b0;
    #1;
    chk("rst_done", done, 1'b0);
    chk("rst_high_time", high_time, 8'd0);
    chk("rst_period", period, 8'd0);
    chk("rst_flag", flag, 2'b00);
    chk("rst_intr", intr, 2'b00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic arm();
    en_lvl = 1'b0;
    seg(1'b0, 8, 1, 1'b0);
    en_lvl = 1'b1;
    seg(1'b0, 10, 1, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit lvl;
    int len;
    int tp;
    inv = 1'b0; intr_en = 2'b00; clr_on_upd = 1'b0;
    do_reset();

    // tick every cycle, 10 high / 30 low
    arm();
    for (int r = 0; r < 4; r++) begin
      seg(1'b1, 10, 1, 1'b0);
      seg(1'b0, 30, 1, 1'b0);
    end
    chk("basic_high_time", high_time, 8'd10);
    chk("basic_period", period, 8'd40);
    chk("basic_done_flag", flag[0], 1'b1);

    // tick every 4th cycle, 40 high / 40 low
    do_reset();
    arm();
    for (int r = 0; r < 3; r++) begin
      seg(1'b1, 40, 4, 1'b0);
      seg(1'b0, 40, 4, 1'b0);
    end
    chk("prescaled_high_time", high_time, 8'd10);
    chk("prescaled_period", period, 8'd20);

    // inverted input, 30 high / 10 low
    inv = 1'b1;
    do_reset();
    arm();
    for (int r = 0; r < 4; r++) begin
      seg(1'b1, 30, 1, 1'b0);
      seg(1'b0, 10, 1, 1'b0);
    end
    chk("inv_high_time", high_time, 8'd10);
    chk("inv_period", period, 8'd40);
    inv = 1'b0;

    // overflow while held high
    intr_en = 2'b10;
    do_reset();
    arm();
    seg(1'b1, 10, 1, 1'b0);
    seg(1'b0, 30, 1, 1'b0);
    seg(1'b1, 10, 1, 1'b0);
    seg(1'b0, 30, 1, 1'b0);
    seg(1'b1, 300, 1, 1'b0);
    chk("ovf_flag", flag[1], 1'b1);
    chk("ovf_intr", intr, 2'b10);
    chk("ovf_high_time_kept", high_time, 8'd10);
    chk("ovf_period_kept", period, 8'd40);
    seg(1'b0, 20, 1, 1'b0);
    seg(1'b1, 10, 1, 1'b0);
    seg(1'b0, 10, 1, 1'b0);
    chk("ovf_rearm_no_result", period, 8'd40);

    // clear colliding with a completed period, then clear alone
    intr_en = 2'b01;
    do_reset();
    arm();
    clr_on_upd = 1'b1;
    for (int r = 0; r < 3; r++) begin
      seg(1'b1, 10, 1, 1'b0);
      seg(1'b0, 30, 1, 1'b0);
    end
    clr_on_upd = 1'b0;
    chk("clr_set_wins", flag[0], 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 2'b01);
    chk("clr_alone", flag[0], 1'b0);

    // no ticks during the phases: edges still complete measurements of 0
    for (int r = 0; r < 3; r++) begin
      seg(1'b1, 20, 0, 1'b0);
      seg(1'b0, 20, 0, 1'b0);
    end
    chk("no_tick_high_time", high_time, 8'd0);
    chk("no_tick_period", period, 8'd0);
    chk("no_tick_done_flag", flag[0], 1'b1);

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    // short glitches are rejected, a pulse of FILT cycles is an edge
    do_reset();
    arm();
    seg(1'b1, 1, 1, 1'b0);
    seg(1'b0, 10, 1, 1'b0);
    seg(1'b1, 2, 1, 1'b0);
    seg(1'b0, 10, 1, 1'b0);
    chk("glitch_no_done", flag[0], 1'b0);
    seg(1'b1, 3, 1, 1'b0);
    seg(1'b0, 10, 1, 1'b0);
    seg(1'b1, 10, 1, 1'b0);
    chk("glitch_pulse_seen", flag[0], 1'b1);
    chk("glitch_period", period, 8'd13);
`endif

    // randomized traffic with occasional disables, clears and a mid-run reset
    for (int r = 0; r < 3; r++) begin
      inv = 1'($urandom_range(0, 1));
      do_reset();
      arm();
      lvl = 1'b0;
      for (int s = 0; s < 60 && k < N - 400; s++) begin
        intr_en = 2'($urandom_range(0, 3));
        len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(200, 320))
                                          : int'($urandom_range(1, 50));
        tp = -int'($urandom_range(0, 4));
        en_lvl = ($urandom_range(0, 19) != 0);
        lvl = ~lvl;
        seg(lvl, len, tp, 1'b1);
        if (r == 1 && s == 30) begin
          do_reset();
          arm();
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
